rx_rss_indir: RTL and testbench
===============================

# rx_rss_indir

Receive-side RSS indirection stage consuming the per-frame flow hash (`crx_hash`/`crx_hash_valid`) produced by the RX hash block. Maps each hash through a software-programmable indirection table to a receive queue index and buffers the decisions in a small FIFO, so the RX engine can pop them with a valid/ready handshake at its own pace. A hash of zero marks a non-hashable frame and is steered to a configurable default queue.

## Interface
- `HASH_WIDTH`, 32, width of incoming hash
- `QUEUE_WIDTH`, 6, queue index width
- `TBL_AW`, 7, log2 of indirection table depth (128 entries)
- `FIFO_AW`, 3, log2 of decision FIFO depth (8 entries)

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `crx_hash`  in  HASH_WIDTH  flow hash, sampled when `crx_hash_valid`=1
- `crx_hash_valid`  in  1  one-cycle strobe per frame; no backpressure
- `cfg_rss_en`  in  1  0: every frame goes to default queue
- `cfg_default_queue`  in  QUEUE_WIDTH  queue for hash==0, RSS disabled, or INIT state
- `cfg_wr_en`  in  1  table write strobe
- `cfg_wr_addr`  in  TBL_AW  table entry address
- `cfg_wr_data`  in  QUEUE_WIDTH  queue index written
- `queue_valid`  out  1  decision available at FIFO head
- `queue_ready`  in  1  RX engine pops head when `queue_valid` & `queue_ready`
- `queue_idx`  out  QUEUE_WIDTH  selected queue
- `queue_hash`  out  HASH_WIDTH  hash that produced the decision
- `init_done`  out  1  table initialisation finished
- `drop_cnt`  out  16  saturating count of decisions lost to FIFO full

## Operation
- FSM states: INIT, RUN. Reset -> INIT. INIT: counter `init_ptr` sweeps 0..2^TBL_AW-1, one entry per cycle, writing entry i = i mod 2^QUEUE_WIDTH; on the last write go to RUN, assert `init_done`. RUN is terminal until reset.
- `cfg_wr_en` ignored in INIT. In RUN writes take effect at the clock edge.
- Stage 1 (cycle of `crx_hash_valid`): index = `crx_hash[TBL_AW-1:0]`; table read registered. Also register hash and a `use_default` flag = (hash==0) | !`cfg_rss_en` | (state==INIT).
- Stage 2: `queue_idx` candidate = `use_default` ? `cfg_default_queue` (value at stage-1 cycle) : table read data. Push {idx, hash} into FIFO.
- Table read/write collision (same address, same cycle): read returns old data.
- FIFO: show-ahead; head drives `queue_idx`/`queue_hash` while `queue_valid`=1. Occupancy counter 0..2^FIFO_AW.
- Push accepted if count < depth, or count == depth and a pop occurs the same cycle. Otherwise decision discarded and `drop_cnt` increments, saturating at 16'hFFFF.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo depth.
- Pop with `queue_valid`=0 has no effect.
- Back-to-back `crx_hash_valid` every cycle fully supported (one decision per cycle).
- Reset mid-operation: FIFO, pipeline and counters cleared; in-flight decisions lost; table re-initialised via INIT.

## Timing
- Reset values: `queue_valid`=0, `queue_idx`=0, `queue_hash`=0, `init_done`=0, `drop_cnt`=0; state INIT, pointers and count 0.
- Latency: `crx_hash_valid` in cycle N -> FIFO write at end of cycle N+1 -> `queue_valid`=1 in cycle N+2 when FIFO was empty.
- INIT lasts exactly 2^TBL_AW cycles after reset release; `init_done` rises in cycle 2^TBL_AW (128 by default).
- Pop at edge ending cycle M: next head (or `queue_valid`=0) visible in cycle M+1.
- `queue_idx`/`queue_hash` held stable while `queue_valid`=1 and `queue_ready`=0.

## Test plan
- Reset, idle 130 cycles -> `init_done` rises in cycle 128; hash 0x0000_0045 -> `queue_idx`=5 (0x45 mod 64), `queue_valid` in cycle N+2.
- Write entry 0x45 = 17, then hash 0xABCD_1245 -> `queue_idx`=17, `queue_hash`=0xABCD1245; same-cycle write to entry 0x45 with a lookup -> old value returned.
- `cfg_default_queue`=9: hash 0 -> 9; `cfg_rss_en`=0 with hash 0x12 -> 9; hash during INIT -> 9.
- `queue_ready`=0, 10 back-to-back hashes -> 8 buffered, `drop_cnt`=2; then `queue_ready`=1 -> 8 decisions in arrival order, then `queue_valid`=0.
- FIFO full with `queue_ready`=1 and new hash each cycle -> no drops, count stays 8, in-order output.
- Assert `rst_n`=0 mid-stream with 5 queued -> `queue_valid`=0 immediately, `drop_cnt`=0, `init_done`=0; INIT repeats and entry 0x45 reads 5 again.

Source files
------------

// File: rtl/rx_rss_indir.sv
// rx_rss_indir: RSS indirection lookup of the per-frame flow hash with a show-ahead decision FIFO
module rx_rss_indir #(
  parameter int HASH_WIDTH  = 32,
  parameter int QUEUE_WIDTH = 6,
  parameter int TBL_AW      = 7,
  parameter int FIFO_AW     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HASH_WIDTH-1:0]  crx_hash,
  input  logic                   crx_hash_valid,
  input  logic                   cfg_rss_en,
  input  logic [QUEUE_WIDTH-1:0] cfg_default_queue,
  input  logic                   cfg_wr_en,
  input  logic [TBL_AW-1:0]      cfg_wr_addr,
  input  logic [QUEUE_WIDTH-1:0] cfg_wr_data,
  output logic                   queue_valid,
  input  logic                   queue_ready,
  output logic [QUEUE_WIDTH-1:0] queue_idx,
  output logic [HASH_WIDTH-1:0]  queue_hash,
  output logic                   init_done,
  output logic [15:0]            drop_cnt
);
  localparam int TBL_D = 1 << TBL_AW;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = QUEUE_WIDTH + HASH_WIDTH;
  typedef enum logic {INIT, RUN} state_e;
  state_e                  state_q, state_d;
  logic [TBL_AW-1:0]       init_ptr_q;
  logic                    init_we, tbl_we;
  logic [TBL_AW-1:0]       tbl_addr;
  logic [QUEUE_WIDTH-1:0]  tbl_data;
  logic [QUEUE_WIDTH-1:0]  tbl_q [TBL_D];
  logic                    s1_valid_q, s1_def_q;
  logic [QUEUE_WIDTH-1:0]  s1_rd_q, s1_dq_q;
  logic [HASH_WIDTH-1:0]   s1_hash_q;
  logic [DW-1:0]           fifo_q [DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]        cnt_q, cnt_d;
  logic [15:0]             drop_q;
  logic                    pop, push_ok;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= INIT;
    else state_q <= state_d;
  // leave INIT once the last table entry has been written; RUN is terminal
  always_comb state_d = (state_q == INIT && &init_ptr_q) ? RUN : state_q;
  // table write port: init sweep owns it in INIT, software in RUN
  always_comb begin
    init_done = state_q == RUN;
    init_we   = state_q == INIT;
    tbl_we    = init_we | cfg_wr_en;
    tbl_addr  = init_we ? init_ptr_q : cfg_wr_addr;
    tbl_data  = init_we ? QUEUE_WIDTH'(init_ptr_q) : cfg_wr_data;
  end
  // init sweep pointer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) init_ptr_q <= '0;
    else if (init_we) init_ptr_q <= init_ptr_q + 1'b1;
  // indirection table storage; rewritten by the init sweep after every reset
  always_ff @(posedge clk)
    if (tbl_we) tbl_q[tbl_addr] <= tbl_data;
  // stage 1: registered table read (old data on collision) plus default decision inputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_def_q   <= 1'b0;
      s1_rd_q    <= '0;
      s1_dq_q    <= '0;
      s1_hash_q  <= '0;
    end else begin
      s1_valid_q <= crx_hash_valid;
      if (crx_hash_valid) begin
        s1_def_q  <= crx_hash == '0 || !cfg_rss_en || state_q == INIT;
        s1_rd_q   <= tbl_q[crx_hash[TBL_AW-1:0]];
        s1_dq_q   <= cfg_default_queue;
        s1_hash_q <= crx_hash;
      end
    end
  // a full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    pop     = queue_valid & queue_ready;
    push_ok = s1_valid_q & (!cnt_q[FIFO_AW] | pop);
    cnt_d   = cnt_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
  end
  // stage 2: push resolved decision
  always_ff @(posedge clk)
    if (push_ok) fifo_q[wr_ptr_q] <= {s1_def_q ? s1_dq_q : s1_rd_q, s1_hash_q};
  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + FIFO_AW'(push_ok);
      rd_ptr_q <= rd_ptr_q + FIFO_AW'(pop);
      cnt_q    <= cnt_d;
      if (s1_valid_q && !push_ok && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  // show-ahead head; outputs read zero while empty
  always_comb begin
    queue_valid             = cnt_q != '0;
    {queue_idx, queue_hash} = queue_valid ? fifo_q[rd_ptr_q] : '0;
    drop_cnt                = drop_q;
  end
endmodule

// File: tb/tb_rx_rss_indir.sv
// tb_rx_rss_indir: randomized and directed checks of rx_rss_indir against a decision-queue model
module tb_rx_rss_indir;
  logic        clk = 0, rst_n = 0;
  logic [31:0] crx_hash = 0;
  logic        crx_hash_valid = 0, cfg_rss_en = 1, cfg_wr_en = 0, queue_ready = 0;
  logic [5:0]  cfg_default_queue = 0, cfg_wr_data = 0;
  logic [6:0]  cfg_wr_addr = 0;
  logic        queue_valid, init_done;
  logic [5:0]  queue_idx;
  logic [31:0] queue_hash;
  logic [15:0] drop_cnt;
  int          cmp = 0, bad = 0;
  int          edges = 0;
  int          mtbl [128];
  logic [37:0] mq [$];
  logic [37:0] pend;
  bit          pend_v = 0;
  int          mdrop = 0;

  rx_rss_indir dut (
    .clk(clk), .rst_n(rst_n), .crx_hash(crx_hash), .crx_hash_valid(crx_hash_valid),
    .cfg_rss_en(cfg_rss_en), .cfg_default_queue(cfg_default_queue), .cfg_wr_en(cfg_wr_en),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .queue_valid(queue_valid),
    .queue_ready(queue_ready), .queue_idx(queue_idx), .queue_hash(queue_hash),
    .init_done(init_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pend_v = 0;
    mdrop  = 0;
    edges  = 0;
    for (int i = 0; i < 128; i++) mtbl[i] = i % 64;
  endtask

  // one clock: model consumes the inputs seen at the edge, then outputs are checked mid-cycle
  task automatic step();
    @(posedge clk);
    if (mq.size() != 0 && queue_ready) void'(mq.pop_front());
    if (pend_v) begin
      if (mq.size() < 8) mq.push_back(pend);
      else if (mdrop < 16'hFFFF) mdrop++;
    end
    pend_v = crx_hash_valid;
    if (crx_hash_valid)
      pend = {(crx_hash == 0 || !cfg_rss_en || edges < 128) ? cfg_default_queue
                                                            : 6'(mtbl[crx_hash[6:0]]), crx_hash};
    if (cfg_wr_en && edges >= 128) mtbl[cfg_wr_addr] = int'(cfg_wr_data);
    edges++;
    @(negedge clk);
    chk("valid", queue_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("idx", queue_idx, mq[0][37:32]);
      chk("hash", queue_hash, mq[0][31:0]);
    end
    chk("drop", drop_cnt, mdrop);
    chk("init_done", init_done, edges >= 128);
  endtask

  task automatic hash_cyc(input logic [31:0] h);
    crx_hash = h;
    crx_hash_valid = 1;
    step();
    crx_hash_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_valid", queue_valid, 0);
    chk("rst_idx", queue_idx, 0);
    chk("rst_hash", queue_hash, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_drop", drop_cnt, 0);
    crx_hash_valid = 0;
    cfg_wr_en = 0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    @(negedge clk);
    cfg_default_queue = 9;
    queue_ready = 1;
    do_reset();
    idle(10);
    hash_cyc(32'h45);
    idle(116);
    chk("init_pre", init_done, 0);
    step();
    chk("init_at_128", init_done, 1);
    idle(2);
    hash_cyc(32'h45);
    chk("lat_n1", queue_valid, 0);
    step();
    chk("lat_n2", queue_valid, 1);
    chk("idx45", queue_idx, 5);
    idle(2);
    cfg_wr_en = 1; cfg_wr_addr = 7'h45; cfg_wr_data = 17;
    step();
    cfg_wr_en = 0;
    hash_cyc(32'hABCD1245);
    step();
    chk("idx17", queue_idx, 17);
    chk("hash_abcd", queue_hash, 32'hABCD1245);
    cfg_wr_en = 1; cfg_wr_data = 33;
    hash_cyc(32'h45);
    cfg_wr_en = 0;
    step();
    chk("collide_old", queue_idx, 17);
    hash_cyc(32'h0);
    step();
    chk("zero_dflt", queue_idx, 9);
    cfg_rss_en = 0;
    hash_cyc(32'h12);
    cfg_rss_en = 1;
    step();
    chk("rss_off_dflt", queue_idx, 9);
    idle(2);
    queue_ready = 0;
    for (int i = 0; i < 10; i++) hash_cyc($urandom);
    idle(2);
    chk("drop2", drop_cnt, 2);
    queue_ready = 1;
    idle(10);
    queue_ready = 0;
    for (int i = 0; i < 8; i++) hash_cyc($urandom);
    idle(2);
    queue_ready = 1;
    for (int i = 0; i < 20; i++) hash_cyc($urandom);
    chk("full_nodrop", drop_cnt, 2);
    idle(10);
    for (int i = 0; i < 600; i++) begin
      crx_hash       = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
      crx_hash_valid = $urandom_range(3) != 0;
      queue_ready    = $urandom_range(2) != 0;
      cfg_rss_en     = $urandom_range(9) != 0;
      cfg_default_queue = 6'($urandom);
      cfg_wr_en      = $urandom_range(3) == 0;
      cfg_wr_addr    = ($urandom_range(1) == 0) ? crx_hash[6:0] : 7'($urandom);
      cfg_wr_data    = 6'($urandom);
      step();
    end
    crx_hash_valid = 0; cfg_wr_en = 0; cfg_rss_en = 1; cfg_default_queue = 9; queue_ready = 1;
    idle(10);
    queue_ready = 0;
    for (int i = 0; i < 5; i++) hash_cyc($urandom);
    idle(2);
    chk("five_queued", queue_valid, 1);
    do_reset();
    queue_ready = 1;
    idle(130);
    hash_cyc(32'h45);
    step();
    chk("reinit45", queue_idx, 5);
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
